// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared state encoding and counter sizing for the serial adder
package serial_adder_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  function automatic int cnt_w(input int w);
    return $clog2(w) + 1;
  endfunction
endpackage

// File: rtl/fulladder.sv
// fulladder: 1-bit full adder cell
module fulladder (
  input  logic a_i,
  input  logic b_i,
  input  logic carry_i,
  output logic sum_o,
  output logic carry_o
);
  assign sum_o   = a_i ^ b_i ^ carry_i;
  assign carry_o = (a_i & b_i) | (carry_i & (a_i ^ b_i));
endmodule

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial adder sequencer, one result bit per clock, LSB first
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             carry_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_o,
  output logic             ovf_o,
  output logic             busy_o
);
  localparam int CW = cnt_w(WIDTH);
  state_t state;
  logic [WIDTH-1:0] a_sr, b_sr, res;
  logic [CW-1:0] cnt;
  logic c, fa_s, fa_c, last;
  fulladder u_fa (
    .a_i    (a_sr[0]),
    .b_i    (b_sr[0]),
    .carry_i(c),
    .sum_o  (fa_s),
    .carry_o(fa_c)
  );
  assign last  = cnt == CW'(WIDTH - 1);
  assign sum_o = res;
  // Sequencer: load operands in IDLE, shift one bit per RUN cycle; on the final
  // bit c is the carry into the MSB, so overflow is c ^ carry-out.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state   <= IDLE;
      ready_o <= 1'b1;
      valid_o <= 1'b0;
      busy_o  <= 1'b0;
      carry_o <= 1'b0;
      ovf_o   <= 1'b0;
      a_sr    <= '0;
      b_sr    <= '0;
      res     <= '0;
      c       <= 1'b0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE: if (valid_i) begin
          a_sr    <= a_i;
          b_sr    <= b_i;
          c       <= carry_i;
          cnt     <= '0;
          state   <= RUN;
          ready_o <= 1'b0;
          busy_o  <= 1'b1;
        end
        RUN: begin
          a_sr <= a_sr >> 1;
          b_sr <= b_sr >> 1;
          res  <= WIDTH'({fa_s, res} >> 1);
          c    <= fa_c;
          cnt  <= cnt + 1'b1;
          if (last) begin
            state   <= DONE;
            busy_o  <= 1'b0;
            valid_o <= 1'b1;
            carry_o <= fa_c;
            ovf_o   <= c ^ fa_c;
          end
        end
        DONE: if (ready_i) begin
          state   <= IDLE;
          valid_o <= 1'b0;
          ready_o <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
